clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_ctrl_pkg.sv | 28 ++
 rtl/clk_gate_ctrl.sv | 107 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// ============================================================================
// Module   : clk_gate_ctrl_pkg
// Brief    : Shared state encoding and counter sizing for clk_gate_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_IDLE = 2'd3
   } clk_gate_ctrl_state_e;

   // Counter must hold both reload values; never narrower than one bit.
   function automatic int cnt_width(input int wake_cyc, input int idle_cyc);
      int m;
      m = 2;
      if (wake_cyc > m) m = wake_cyc;
      if (idle_cyc > m) m = idle_cyc;
      return $clog2(m);
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Sequences a downstream clock gate: wake on demand, settle before
//            ack, gate again after an idle hold-off.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_gate_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               force_on_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               ena_o,
   output logic [1:0]         state_o
);

   localparam int CW = cnt_width(WAKE_CYC, IDLE_CYC);

   localparam logic [CW-1:0] c_wake_load = CW'(WAKE_CYC - 1);
   localparam logic [CW-1:0] c_idle_load = CW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);
   localparam logic [CW-1:0] c_cnt_one   = CW'(1);

   clk_gate_ctrl_state_e r_state;
   clk_gate_ctrl_state_e w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic                 r_ena;
   logic                 w_demand;
   logic                 w_granted;

   assign w_demand = (|req_i) | force_on_i;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_OFF: begin
            if (w_demand) begin
               w_state_nxt = ST_WAKE;
               w_cnt_nxt   = c_wake_load;
            end
         end
         // Settle interval always completes, even if demand vanishes.
         ST_WAKE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_ON;
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_one;
            end
         end
         ST_ON: begin
            if (!w_demand) begin
               if (IDLE_CYC == 0) begin
                  w_state_nxt = ST_OFF;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = c_idle_load;
               end
            end
         end
         // Returning demand takes priority over an expiring hold-off.
         ST_IDLE: begin
            if (w_demand) begin
               w_state_nxt = ST_ON;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_OFF;
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_one;
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_OFF;
         r_cnt   <= '0;
         r_ena   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ena   <= (w_state_nxt != ST_OFF);
      end
   end

   // Grant only once the gated clock has settled; falls with req_i directly.
   assign w_granted = (r_state == ST_ON) || (r_state == ST_IDLE);
   assign ack_o     = req_i & {NUM_REQ{w_granted}};
   assign ena_o     = r_ena;
   assign state_o   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Brief    : Scoreboard bench for clk_gate_ctrl with a timing-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_gate_ctrl;

   localparam int NR = 4;
   localparam int WK = 2;
   localparam int ID = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          force_on;
   logic [NR-1:0] req;
   logic [NR-1:0] ack1, ack0;
   logic          ena1, ena0;
   logic [1:0]    st1, st0;

   int total = 0;
   int bad   = 0;
   int pops  = 0;

   always #5 clk = ~clk;

   clk_gate_ctrl #(.NUM_REQ(NR), .WAKE_CYC(WK), .IDLE_CYC(ID)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .force_on_i(force_on),
      .ack_o(ack1), .ena_o(ena1), .state_o(st1)
   );

   clk_gate_ctrl #(.NUM_REQ(NR), .WAKE_CYC(WK), .IDLE_CYC(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .force_on_i(force_on),
      .ack_o(ack0), .ena_o(ena0), .state_o(st0)
   );

   // Model: clock enabled flag, edges left until settled, edges without demand.
   typedef struct {
      bit ena;
      int wake_rem;
      int quiet;
   } mdl_t;

   typedef struct {
      logic [1:0]    st1;
      logic          ena1;
      logic [NR-1:0] ack1;
      logic [1:0]    st0;
      logic          ena0;
      logic [NR-1:0] ack0;
   } exp_t;

   mdl_t m1 = '{0, 0, 0};
   mdl_t m0 = '{0, 0, 0};
   exp_t sb[$];
   exp_t e;

   function automatic mdl_t mdl_step(mdl_t m, bit d, int idle);
      mdl_t n = m;
      if (!m.ena) begin
         if (d) begin
            n.ena      = 1'b1;
            n.wake_rem = WK;
            n.quiet    = 0;
         end
      end else if (m.wake_rem > 0) begin
         n.wake_rem = m.wake_rem - 1;
      end else if (d) begin
         n.quiet = 0;
      end else begin
         n.quiet = m.quiet + 1;
         if (n.quiet > idle) begin
            n.ena   = 1'b0;
            n.quiet = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [1:0] mdl_state(mdl_t m);
      if (!m.ena)           return 2'd0;
      if (m.wake_rem > 0)   return 2'd1;
      if (m.quiet == 0)     return 2'd2;
      return 2'd3;
   endfunction

   function automatic exp_t mk_exp(mdl_t a, mdl_t b, logic [NR-1:0] r);
      exp_t x;
      x.st1  = mdl_state(a);
      x.ena1 = a.ena;
      x.ack1 = (a.ena && a.wake_rem == 0) ? r : '0;
      x.st0  = mdl_state(b);
      x.ena0 = b.ena;
      x.ack0 = (b.ena && b.wake_rem == 0) ? r : '0;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Stimulus side: expected post-edge response is queued at every edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1 <= '{0, 0, 0};
         m0 <= '{0, 0, 0};
         sb.delete();
      end else begin
         sb.push_back(mk_exp(mdl_step(m1, (|req) || force_on, ID),
                             mdl_step(m0, (|req) || force_on, 0), req));
         m1 <= mdl_step(m1, (|req) || force_on, ID);
         m0 <= mdl_step(m0, (|req) || force_on, 0);
      end
   end

   // Monitor side.
   always @(posedge clk) begin
      #1;
      if (!rst && sb.size() > 0) begin
         e = sb.pop_front();
         pops++;
         chk("sb_state",  32'(st1),  32'(e.st1));
         chk("sb_ena",    32'(ena1), 32'(e.ena1));
         chk("sb_ack",    32'(ack1), 32'(e.ack1));
         chk("sb_state0", 32'(st0),  32'(e.st0));
         chk("sb_ena0",   32'(ena0), 32'(e.ena0));
         chk("sb_ack0",   32'(ack0), 32'(e.ack0));
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if ((|ack1 && !ena1) || (|ack0 && !ena0)) begin
            bad++;
            $display("FAIL ack_without_ena: ack1=%b ena1=%b ack0=%b ena0=%b", ack1, ena1, ack0, ena0);
         end
      end
   end

   task automatic async_rst(input string nm);
      #2 rst = 1'b1;
      #1;
      chk({nm, "_ena"},  32'(ena1), 32'd0);
      chk({nm, "_ack"},  32'(ack1), 32'd0);
      chk({nm, "_st"},   32'(st1),  32'd0);
      chk({nm, "_ena0"}, 32'(ena0), 32'd0);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_wake, n_on, n_idle;
      logic [NR-1:0] ack_seen;
      rst      = 1'b1;
      force_on = 1'b0;
      req      = 4'b0101;
      repeat (3) @(negedge clk);
      chk("rst_ena",   32'(ena1), 32'd0);
      chk("rst_ack",   32'(ack1), 32'd0);
      chk("rst_state", 32'(st1),  32'd0);
      chk("rst_ack0",  32'(ack0), 32'd0);

      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("ack_before_3_edges", 32'(ack1), 32'd0);
      @(posedge clk);
      #1 chk("ack_at_3_edges", 32'(ack1), 32'b0101);

      // Single-cycle request never gets acked.
      @(negedge clk) req = '0;
      repeat (12) @(negedge clk);
      req = 4'b0100;
      @(negedge clk) req = '0;
      n_wake = 0; n_on = 0; n_idle = 0; ack_seen = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (st1 == 2'd1) n_wake++;
         if (st1 == 2'd2) n_on++;
         if (st1 == 2'd3) n_idle++;
         ack_seen |= ack1;
      end
      chk("pulse_wake_cycles", 32'(n_wake), 32'd2);
      chk("pulse_on_cycles",   32'(n_on),   32'd1);
      chk("pulse_idle_cycles", 32'(n_idle), 32'd4);
      chk("pulse_ack_never",   32'(ack_seen), 32'd0);

      // Demand returning in the last idle cycle wins over gating.
      req = 4'b0010;
      repeat (4) @(negedge clk);
      req = '0;
      @(posedge clk);
      #1;
      chk("idle0_off_ena", 32'(ena0), 32'd0);
      chk("idle0_off_st",  32'(st0),  32'd0);
      chk("idle_entered",  32'(st1),  32'd3);
      repeat (4) @(negedge clk);
      chk("idle_last_cycle", 32'(st1), 32'd3);
      req = 4'b1000;
      @(posedge clk);
      #1;
      chk("demand_wins_state", 32'(st1),  32'd2);
      chk("demand_wins_ack",   32'(ack1), 32'b1000);
      @(negedge clk) req = '0;
      repeat (8) @(negedge clk);

      // Software override keeps the clock running without acks.
      force_on = 1'b1;
      repeat (100) @(negedge clk);
      chk("force_state", 32'(st1),  32'd2);
      chk("force_ena",   32'(ena1), 32'd1);
      chk("force_ack",   32'(ack1), 32'd0);
      force_on = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("force_drop_4", 32'(ena1), 32'd1);
      @(posedge clk);
      #1 chk("force_drop_5", 32'(ena1), 32'd0);

      // Asynchronous reset in WAKE, ON (acked) and IDLE.
      @(negedge clk) req = 4'b0001;
      @(negedge clk);
      chk("pre_rst_wake", 32'(st1), 32'd1);
      async_rst("rst_wake");
      req = 4'b0011;
      repeat (4) @(negedge clk);
      chk("pre_rst_on_ack", 32'(ack1), 32'b0011);
      async_rst("rst_on");
      repeat (4) @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);
      chk("pre_rst_idle", 32'(st1), 32'd3);
      async_rst("rst_idle");

      // Randomised stress with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0)
            req = ($urandom_range(0, 1) == 0) ? '0 : NR'($urandom);
         force_on = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 299) == 0) async_rst("rst_rand");
      end
      @(negedge clk);
      req = '0;
      force_on = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("sb_active",  32'(pops > 1000), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
